// File: rtl/gemm_pkg.sv
// Shared types and helpers for the GEMM job sequencer and the MAC-array input manager.
package gemm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      DONE
   } gemm_seq_state_t;

   localparam int unsigned GEMM_OP_WIDTH = 8;
   localparam int unsigned MAX_OP_WIDTH  = 32;
   localparam int unsigned MAX_MAT_BITS  = 16 * 16 * MAX_OP_WIDTH;

   // Element [r][c] of a row-major packed n x n matrix of w-bit elements (low bits valid).
   function automatic logic [MAX_OP_WIDTH-1:0] elem(input logic [MAX_MAT_BITS-1:0] mat,
                                                    input int unsigned r,
                                                    input int unsigned c,
                                                    input int unsigned n,
                                                    input int unsigned w);
      return MAX_OP_WIDTH'(mat >> (w * (r * n + c)));
   endfunction

endpackage

// File: rtl/gemm_skew_mux.sv
// Builds the skewed A-column / B-row wavefront for feed step t from the latched operands.
module gemm_skew_mux
   import gemm_pkg::*;
#(
   parameter int unsigned OP_WIDTH = GEMM_OP_WIDTH,
   parameter int unsigned N        = 2
) (
   input  logic [N*N*OP_WIDTH-1:0]    a,
   input  logic [N*N*OP_WIDTH-1:0]    b,
   input  logic [$clog2(2*N)-1:0]     t,
   output logic [N*OP_WIDTH-1:0]      a_col_c,
   output logic [N*OP_WIDTH-1:0]      b_row_c
);

   localparam int unsigned TW = $clog2(2 * N);
   localparam int unsigned DW = TW + 1;

   // One extra bit so t - lane going negative shows up in the MSB instead of wrapping.
   logic [DW-1:0] d;

   always_comb begin
      a_col_c = '0;
      b_row_c = '0;
      d       = '0;
      for (int unsigned i = 0; i < N; i++) begin
         d = {1'b0, t} - DW'(i);
         if (!d[DW-1] && (d < DW'(N))) begin
            a_col_c[OP_WIDTH*i +: OP_WIDTH] =
               OP_WIDTH'(elem(MAX_MAT_BITS'(a), i, 32'(d), N, OP_WIDTH));
            b_row_c[OP_WIDTH*i +: OP_WIDTH] =
               OP_WIDTH'(elem(MAX_MAT_BITS'(b), 32'(d), i, N, OP_WIDTH));
         end
      end
   end

endmodule

// File: rtl/gemm_sequencer.sv
// Job-level controller: latches one operand pair, clears the array, feeds skewed
// wavefronts, waits for the array to drain, then pulses done.
module gemm_sequencer
   import gemm_pkg::*;
#(
   parameter int unsigned OP_WIDTH = GEMM_OP_WIDTH,
   parameter int unsigned N        = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start_valid,
   output logic                    start_ready,
   input  logic [N*N*OP_WIDTH-1:0] A,
   input  logic [N*N*OP_WIDTH-1:0] B,
   output logic [N*OP_WIDTH-1:0]   new_a_column,
   output logic [N*OP_WIDTH-1:0]   new_b_row,
   output logic                    feed_valid,
   output logic                    clear_acc,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned TW = $clog2(2 * N);
   localparam int unsigned MW = N * N * OP_WIDTH;
   localparam int unsigned LW = N * OP_WIDTH;

   gemm_seq_state_t state, state_nxt;
   logic [TW-1:0]   step, step_nxt;
   logic [MW-1:0]   a_lat, b_lat;
   logic            accept_c;
   logic [LW-1:0]   a_col_c, b_row_c;
   logic [LW-1:0]   a_col_nxt, b_row_nxt;
   logic            ready_nxt, feed_nxt, clear_nxt, done_nxt;

   assign accept_c = start_valid && start_ready;

   // State register and step counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         step  <= '0;
      end else begin
         state <= state_nxt;
         step  <= step_nxt;
      end
   end

   // Next state; the counter restarts on entry to FEED and DRAIN
   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      case (state)
         IDLE:  if (accept_c) state_nxt = CLEAR;
         CLEAR: begin
            state_nxt = FEED;
            step_nxt  = '0;
         end
         FEED: begin
            if (step == TW'(2 * N - 2)) begin
               state_nxt = DRAIN;
               step_nxt  = '0;
            end else begin
               step_nxt = step + TW'(1);
            end
         end
         DRAIN: begin
            step_nxt = step + TW'(1);
            if (step == TW'(N - 1)) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   gemm_skew_mux #(.OP_WIDTH(OP_WIDTH), .N(N)) u_skew (
      .a       (a_lat),
      .b       (b_lat),
      .t       (step_nxt),
      .a_col_c (a_col_c),
      .b_row_c (b_row_c)
   );

   // Output decode from the upcoming state so every output comes straight off a flop
   always_comb begin
      ready_nxt = (state_nxt == IDLE);
      feed_nxt  = (state_nxt == FEED);
      clear_nxt = (state_nxt == CLEAR);
      done_nxt  = (state_nxt == DONE);
      a_col_nxt = feed_nxt ? a_col_c : '0;
      b_row_nxt = feed_nxt ? b_row_c : '0;
   end

   // Operand latch and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         a_lat        <= '0;
         b_lat        <= '0;
         start_ready  <= 1'b1;
         busy         <= 1'b0;
         feed_valid   <= 1'b0;
         clear_acc    <= 1'b0;
         done         <= 1'b0;
         new_a_column <= '0;
         new_b_row    <= '0;
      end else begin
         if (accept_c) begin
            a_lat <= A;
            b_lat <= B;
         end
         start_ready  <= ready_nxt;
         busy         <= !ready_nxt;
         feed_valid   <= feed_nxt;
         clear_acc    <= clear_nxt;
         done         <= done_nxt;
         new_a_column <= a_col_nxt;
         new_b_row    <= b_row_nxt;
      end
   end

endmodule

// File: doc/gemm_sequencer.md
# gemm_sequencer

Job-level controller for the systolic MAC array. It accepts one pair of N×N operand matrices through a valid/ready handshake and latches them. It then clears the array accumulators and drives the skewed A-column and B-row wavefronts into the array's input manager. After the array has drained, it pulses `done`. It sits between the host/command interface and the MAC array's `new_a_column` / `new_b_row` inputs, so the array's own input logic needs no state of its own.

## Interface
- `OP_WIDTH`, 8, operand element width in bits.
- `N`, 2, array dimension; legal range 2..16.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `start_valid` input 1: job request; A and B are valid while high.
- `start_ready` output 1: high only in IDLE.
- `A` input N*N*OP_WIDTH: row-major; A[r][c] at bits [OP_WIDTH*(r*N+c) +: OP_WIDTH].
- `B` input N*N*OP_WIDTH: same packing as A.
- `new_a_column` output N*OP_WIDTH: lane i (row i) at [OP_WIDTH*i +: OP_WIDTH].
- `new_b_row` output N*OP_WIDTH: lane j (column j) at [OP_WIDTH*j +: OP_WIDTH].
- `feed_valid` output 1: high during FEED.
- `clear_acc` output 1: one-cycle accumulator clear to the array.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when results are final in the array.

## Operation
- **Accept:** a job is accepted when `start_valid && start_ready` on a rising edge. A and B are captured into internal registers, so inputs may change afterwards.
- **States and transitions:**
  - IDLE → CLEAR on accept.
  - CLEAR (1 cycle) → FEED.
  - FEED (2N-1 cycles) → DRAIN.
  - DRAIN (N cycles) → DONE.
  - DONE (1 cycle) → IDLE.
- **Step counter:** width $clog2(2N). It is zeroed on entry to FEED and to DRAIN, and increments each cycle in those states.
- **Feed wavefront at step t (0..2N-2):**
  - a lane i = A[i][t-i] if 0 ≤ t-i < N, else 0.
  - b lane j = B[t-j][j] if 0 ≤ t-j < N, else 0.
- **Outside FEED:** `new_a_column` and `new_b_row` are all-zero (registered zero, no X).
- **`clear_acc`:** high exactly in CLEAR.
- **`done`:** high exactly in DONE.
- **`busy`:** equals `!start_ready`.
- **Ignored requests:** `start_valid` outside IDLE is ignored and does not queue.
- **Reset:** `reset` in any state forces IDLE and zeroes the counter, the latched operands and all outputs. A partially fed job is abandoned with no `done`; the array is cleared by the next job's CLEAR.
- **Arithmetic:** index arithmetic uses unsigned widths wide enough for 2N, so t-i < 0 is detected without wrap. Operands pass through unmodified; no sign handling here.

## Timing
- **Reset values:**
  - `start_ready`=1.
  - `busy`=0, `feed_valid`=0, `clear_acc`=0, `done`=0.
  - `new_a_column`=0, `new_b_row`=0.
- **Cycle numbering:** outputs are registered; cycle k means k edges after the accept edge (accept edge = cycle 0 boundary).
  - Cycle 1: CLEAR.
  - Cycles 2..2N: FEED, steps 0..2N-2.
  - Cycles 2N+1..3N: DRAIN.
  - Cycle 3N+1: DONE.
  - Cycle 3N+2: IDLE, `start_ready`=1.
- **Why N drain cycles:** the last product, A[N-1][N-1]·B[N-1][N-1], reaches PE(N-1,N-1) at feed-relative cycle 3N-3. N drain cycles cover that hop plus the MAC register.
- **Job rate:** minimum job-to-job spacing is 3N+2 cycles, and there is no back-to-back accept in DONE.
- **N=2 example:** CLEAR at 1, FEED at 2-4, DRAIN at 5-6, DONE at 7, ready at 8.

## Structure
- **Package `gemm_pkg`:**
  - state enum `gemm_seq_state_t` {IDLE, CLEAR, FEED, DRAIN, DONE}.
  - default `OP_WIDTH`.
  - function `elem(mat, r, c, N, W)` for packed element extraction, shared with the MAC-array input manager.
- **Sub-module `gemm_skew_mux`:** combinational. Takes the latched A and B plus step t, and produces the two lane vectors. The sequencer registers its output.
- **`gemm_sequencer` itself:** FSM, step counter, operand latch, output registers.

## Test plan
- **Basic job, N=2:** A rows [1,2],[3,4]; B rows [5,6],[7,8]; one-cycle `start_valid` at idle. Required response:
  - `clear_acc` at cycle 1.
  - FEED cycle 2: `new_a_column`={0,1}, `new_b_row`={0,5}.
  - FEED cycle 3: a={3,2}, b={6,7}.
  - FEED cycle 4: a={4,0}, b={8,0}.
  - `done` only at cycle 7; `start_ready` back at cycle 8.
- **Input change after accept:** change A/B to all 0xFF at cycle 1 → the feed values still match the latched matrices above.
- **Request while busy:** hold `start_valid` high for the whole job → exactly one accept per 3N+2 cycles, and the second job's CLEAR lands at cycle 9.
- **Reset mid-FEED:** assert `reset` at cycle 3 → next cycle IDLE, all outputs 0, no `done` pulse. A fresh job then runs with the nominal timing.
- **N=4 sweep:** random 8-bit matrices; a bench model computes the wavefront → every lane matches A[i][t-i] / B[t-j][j] for all 7 steps, and `done` lands at cycle 13.
- **Idle stability:** no `start_valid` for 50 cycles after reset → `start_ready`=1 and all other outputs remain 0.
